// File: rtl/life_pkg.sv
// Purpose: shared types for the LED matrix scanner (frame shape, scan states, row decode).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package life_pkg;

  localparam int GRID_N = 8;
  localparam int ROW_W  = $clog2(GRID_N);

  // Board frame, indexed [row][col]; 1 = cell alive / LED lit.
  typedef logic [GRID_N-1:0][GRID_N-1:0] frame_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  // One-hot active-high row drive for a row index.
  function automatic logic [GRID_N-1:0] row_onehot(input logic [ROW_W-1:0] r);
    logic [GRID_N-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Purpose: groups the scanner's frame-load handshake and display outputs into one bundle.
// Latency: n/a (wiring only).
// Backpressure: none; frame_load is a fire-and-forget pulse, load_ack reports the swap.
// Ports: none; master drives enable/frame_in/frame_load, slave drives the display side.
interface led_matrix_scan_if;
  import life_pkg::*;

  logic              enable;
  frame_t            frame_in;
  logic              frame_load;
  logic              load_ack;
  logic [GRID_N-1:0] row_sel;
  logic [GRID_N-1:0] col_on;
  logic              frame_done;

  modport master (
    output enable, frame_in, frame_load,
    input  load_ack, row_sel, col_on, frame_done
  );

  modport slave (
    input  enable, frame_in, frame_load,
    output load_ack, row_sel, col_on, frame_done
  );

endinterface

// File: rtl/led_matrix_scan.sv
// Purpose: scans a double-buffered 8x8 frame onto a row-multiplexed LED matrix (blank, then drive, per row).
// Latency: all outputs registered; a loaded frame becomes visible at the next row-0 boundary.
// Backpressure: none; frame_load is always accepted and a newer load replaces one not yet shown.
// Ports: clk, reset_n (async, active-low); in: enable, frame_in, frame_load;
//        out: load_ack (swap pulse), row_sel (one-hot), col_on (row data), frame_done (row-7 end pulse).
module led_matrix_scan
  import life_pkg::*;
#(
  parameter int unsigned DWELL = 1024,
  parameter int unsigned BLANK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  frame_t            frame_in,
  input  logic              frame_load,
  output logic              load_ack,
  output logic [GRID_N-1:0] row_sel,
  output logic [GRID_N-1:0] col_on,
  output logic              frame_done
);

  // One counter serves both phases; it never needs to exceed the longer one.
  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  scan_state_t       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  frame_t            pending_q, active_q;
  logic              pending_vld_q;
  logic              swap;
  logic              load_ack_d, frame_done_d;
  logic [GRID_N-1:0] row_sel_d, col_on_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      pending_vld_q <= 1'b0;
      load_ack      <= 1'b0;
      frame_done    <= 1'b0;
      row_sel       <= '0;
      col_on        <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      // The swap reads the old pending; a same-edge load then refills it.
      if (swap) active_q <= pending_q;
      if (frame_load) begin
        pending_q     <= frame_in;
        pending_vld_q <= 1'b1;
      end else if (swap) begin
        pending_vld_q <= 1'b0;
      end
      load_ack   <= load_ack_d;
      frame_done <= frame_done_d;
      row_sel    <= row_sel_d;
      col_on     <= col_on_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    swap         = 1'b0;
    frame_done_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Entering row-0 blank: the only point a new frame may be adopted.
          state_d = S_BLANK;
          row_d   = '0;
          cnt_d   = '0;
          swap    = pending_vld_q;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d      = S_BLANK;
            cnt_d        = '0;
            row_d        = row_q + ROW_W'(1);
            frame_done_d = (row_q == ROW_W'(GRID_N - 1));
            swap         = pending_vld_q && (row_q == ROW_W'(GRID_N - 1));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they line up with it once registered.
    load_ack_d = swap;
    row_sel_d  = (state_d == S_DRIVE) ? row_onehot(row_d) : '0;
    col_on_d   = (state_d == S_DRIVE) ? active_q[row_d] : '0;
  end

endmodule
